// File: rtl/vector_pingpong_store.sv
// vector_pingpong_store: double-banked chunk memory holding one CG vector; the Alu reads the current bank while its write-back fills the next one
module vector_pingpong_store #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int memory_height = 1000,
    parameter int address_width = $clog2(memory_height) + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [31:0]                          total,
    input  logic                                 wr_en,
    input  logic [element_width*no_of_units-1:0] wr_data,
    input  logic                                 seq_rd,
    input  logic                                 rnd_rd,
    input  logic [31:0]                          rnd_addr,
    input  logic                                 swap,
    output logic [element_width*no_of_units-1:0] seq_data,
    output logic                                 seq_valid,
    output logic                                 seq_last,
    output logic [element_width*no_of_units-1:0] rnd_data,
    output logic                                 rnd_valid,
    output logic [31:0]                          wr_count,
    output logic                                 wr_full,
    output logic                                 bank_sel,
    output logic [2:0]                           err
);
    localparam int DW = element_width * no_of_units;
    localparam int IW = $clog2(memory_height);

    logic [DW-1:0]            mem [2][memory_height];
    logic [31:0]              chunks;
    logic                     wr_ok, seq_wrap, rnd_oob;
    logic [address_width-1:0] wr_ptr_q, wr_ptr_d, seq_ptr_q, seq_ptr_d;
    logic                     bank_sel_q, bank_sel_d;
    logic [2:0]               err_q, err_d;
    logic [DW-1:0]            seq_data_q, seq_data_d, rnd_data_q, rnd_data_d;
    logic                     seq_valid_q, seq_last_q, rnd_valid_q;

    // Next-state: pointer advance/wrap, swap clears pointers, sticky errors, read data capture from the current bank
    always_comb begin
        chunks     = total / 32'(no_of_units);
        wr_ok      = wr_en && (32'(wr_ptr_q) < chunks);
        seq_wrap   = (32'(seq_ptr_q) + 32'd1) >= chunks;
        rnd_oob    = rnd_addr >= chunks;
        wr_ptr_d   = swap ? '0 : wr_ptr_q + address_width'(wr_ok);
        seq_ptr_d  = (swap || (seq_rd && seq_wrap)) ? '0 : seq_ptr_q + address_width'(seq_rd);
        bank_sel_d = bank_sel_q ^ swap;
        err_d      = err_q | {swap && ((32'(wr_ptr_q) + 32'(wr_ok)) != chunks),
                              rnd_rd && rnd_oob,
                              wr_en && !wr_ok};
        seq_data_d = seq_rd ? mem[bank_sel_q][seq_ptr_q[IW-1:0]] : seq_data_q;
        rnd_data_d = rnd_rd ? (rnd_oob ? '0 : mem[bank_sel_q][rnd_addr[IW-1:0]]) : rnd_data_q;
    end

    // State and output registers; reset abandons any in-flight read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            seq_ptr_q   <= '0;
            bank_sel_q  <= 1'b0;
            err_q       <= '0;
            seq_data_q  <= '0;
            rnd_data_q  <= '0;
            seq_valid_q <= 1'b0;
            seq_last_q  <= 1'b0;
            rnd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            seq_ptr_q   <= seq_ptr_d;
            bank_sel_q  <= bank_sel_d;
            err_q       <= err_d;
            seq_data_q  <= seq_data_d;
            rnd_data_q  <= rnd_data_d;
            seq_valid_q <= seq_rd;
            seq_last_q  <= seq_rd && seq_wrap;
            rnd_valid_q <= rnd_rd;
        end
    end

    // Write-back always lands in the bank not being read, so no bypass is needed
    always_ff @(posedge clk) begin
        if (wr_ok) mem[~bank_sel_q][wr_ptr_q[IW-1:0]] <= wr_data;
    end

    assign seq_data  = seq_data_q;
    assign seq_valid = seq_valid_q;
    assign seq_last  = seq_last_q;
    assign rnd_data  = rnd_data_q;
    assign rnd_valid = rnd_valid_q;
    assign wr_count  = 32'(wr_ptr_q);
    assign wr_full   = wr_count == chunks;
    assign bank_sel  = bank_sel_q;
    assign err       = err_q;
endmodule

// File: tb/tb_vector_pingpong_store.sv
// tb_vector_pingpong_store: scoreboard bench for the ping-pong vector store
module tb_vector_pingpong_store;
    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  total;
    logic         wr_en;
    logic [255:0] wr_data;
    logic         seq_rd;
    logic         rnd_rd;
    logic [31:0]  rnd_addr;
    logic         swap;
    logic [255:0] seq_data;
    logic         seq_valid;
    logic         seq_last;
    logic [255:0] rnd_data;
    logic         rnd_valid;
    logic [31:0]  wr_count;
    logic         wr_full;
    logic         bank_sel;
    logic [2:0]   err;

    int n_chk = 0;
    int n_fail = 0;
    logic [256:0] seq_q[$];
    logic [255:0] rnd_q[$];

    vector_pingpong_store dut (
        .clk(clk), .reset(reset), .total(total), .wr_en(wr_en), .wr_data(wr_data),
        .seq_rd(seq_rd), .rnd_rd(rnd_rd), .rnd_addr(rnd_addr), .swap(swap),
        .seq_data(seq_data), .seq_valid(seq_valid), .seq_last(seq_last),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .wr_count(wr_count),
        .wr_full(wr_full), .bank_sel(bank_sel), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [7:0] tag, input int i);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = {tag, 16'h0, 8'(i * 8 + k)};
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [255:0] d);
        wr_en = 1'b1;
        wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic sr(input logic [255:0] d, input logic l);
        seq_rd = 1'b1;
        seq_q.push_back({l, d});
        cyc();
        seq_rd = 1'b0;
    endtask

    task automatic rr(input logic [31:0] a, input logic [255:0] d);
        rnd_rd = 1'b1;
        rnd_addr = a;
        rnd_q.push_back(d);
        cyc();
        rnd_rd = 1'b0;
    endtask

    task automatic status(input string tag, input logic bs, input logic [2:0] e, input int wc, input logic wf);
        chk({tag, "_bank_sel"}, 256'(bank_sel), 256'(bs));
        chk({tag, "_err"}, 256'(err), 256'(e));
        chk({tag, "_wr_count"}, 256'(wr_count), 256'(wc));
        chk({tag, "_wr_full"}, 256'(wr_full), 256'(wf));
    endtask

    // Monitor: pop the expected response whenever the DUT presents a valid
    always @(negedge clk) begin
        logic [256:0] e;
        if (seq_valid) begin
            if (seq_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL seq_unexpected: got seq_valid=1 expected no response");
            end else begin
                e = seq_q.pop_front();
                chk("seq_data", seq_data, e[255:0]);
                chk("seq_last", 256'(seq_last), 256'(e[256]));
            end
        end
        if (rnd_valid) begin
            if (rnd_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rnd_unexpected: got rnd_valid=1 expected no response");
            end else begin
                chk("rnd_data", rnd_data, rnd_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b0;
        total = 32;
        wr_en = 1'b0;
        wr_data = '0;
        seq_rd = 1'b0;
        rnd_rd = 1'b0;
        rnd_addr = '0;
        swap = 1'b0;
        repeat (2) cyc();
        chk("rst_seq_valid", 256'(seq_valid), 256'(0));
        chk("rst_rnd_valid", 256'(rnd_valid), 256'(0));
        chk("rst_seq_data", seq_data, '0);
        chk("rst_rnd_data", rnd_data, '0);
        chk("rst_seq_last", 256'(seq_last), 256'(0));
        status("rst", 1'b0, 3'b000, 0, 1'b0);
        reset = 1'b1;
        cyc();
        // initial load into bank 1, then swap it in
        for (int i = 0; i < 4; i++) wr(mk(8'hD0, i));
        status("load", 1'b0, 3'b000, 4, 1'b1);
        swap = 1'b1;
        cyc();
        swap = 1'b0;
        status("swap1", 1'b1, 3'b000, 0, 1'b0);
        for (int i = 0; i < 4; i++) sr(mk(8'hD0, i), i == 3);
        sr(mk(8'hD0, 0), 1'b0);
        for (int i = 1; i < 4; i++) sr(mk(8'hD0, i), i == 3);
        chk("stream_err", 256'(err), 256'(0));
        // ping-pong: fill bank 0 while streaming bank 1
        for (int i = 0; i < 4; i++) begin
            seq_rd = 1'b1;
            wr_en = 1'b1;
            wr_data = mk(8'hE0, i);
            seq_q.push_back({i == 3, mk(8'hD0, i)});
            cyc();
        end
        seq_rd = 1'b0;
        wr_en = 1'b0;
        status("pp_load", 1'b1, 3'b000, 4, 1'b1);
        wr(mk(8'hEF, 9));
        status("overflow", 1'b1, 3'b001, 4, 1'b1);
        swap = 1'b1;
        cyc();
        swap = 1'b0;
        status("swap2", 1'b0, 3'b001, 0, 1'b0);
        for (int i = 0; i < 4; i++) sr(mk(8'hE0, i), i == 3);
        // addressed reads
        rr(2, mk(8'hE0, 2));
        chk("rnd_in_err", 256'(err), 256'(3'b001));
        rr(7, '0);
        chk("rnd_oob_err", 256'(err), 256'(3'b011));
        seq_rd = 1'b1;
        rnd_rd = 1'b1;
        rnd_addr = 1;
        seq_q.push_back({1'b0, mk(8'hE0, 0)});
        rnd_q.push_back(mk(8'hE0, 1));
        cyc();
        seq_rd = 1'b0;
        rnd_rd = 1'b0;
        // swap collision: write, seq and rnd read all in the swap cycle
        wr(mk(8'hF0, 0));
        wr(mk(8'hF0, 1));
        chk("pre_coll_count", 256'(wr_count), 256'(2));
        swap = 1'b1;
        wr_en = 1'b1;
        wr_data = mk(8'hF0, 2);
        seq_rd = 1'b1;
        rnd_rd = 1'b1;
        rnd_addr = 3;
        seq_q.push_back({1'b0, mk(8'hE0, 1)});
        rnd_q.push_back(mk(8'hE0, 3));
        cyc();
        swap = 1'b0;
        wr_en = 1'b0;
        seq_rd = 1'b0;
        rnd_rd = 1'b0;
        status("collision", 1'b1, 3'b111, 0, 1'b0);
        sr(mk(8'hF0, 0), 1'b0);
        sr(mk(8'hF0, 1), 1'b0);
        sr(mk(8'hF0, 2), 1'b0);
        sr(mk(8'hD0, 3), 1'b1);
        repeat (2) cyc();
        // asynchronous reset in the middle of a read strobe
        seq_rd = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_seq_valid", 256'(seq_valid), 256'(0));
        chk("arst_seq_data", seq_data, '0);
        chk("arst_rnd_data", rnd_data, '0);
        status("arst", 1'b0, 3'b000, 0, 1'b0);
        cyc();
        seq_rd = 1'b0;
        reset = 1'b1;
        repeat (2) cyc();
        // chunks == 0 corner
        total = 4;
        #1;
        chk("zero_wr_full", 256'(wr_full), 256'(1));
        sr(mk(8'hE0, 0), 1'b1);
        sr(mk(8'hE0, 0), 1'b1);
        rr(0, '0);
        wr(mk(8'hAA, 0));
        status("zero", 1'b0, 3'b011, 0, 1'b1);
        total = 32;
        sr(mk(8'hE0, 0), 1'b0);
        repeat (3) cyc();
        chk("seq_q_drained", 256'(seq_q.size()), 256'(0));
        chk("rnd_q_drained", 256'(rnd_q.size()), 256'(0));
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/vector_pingpong_store.md
Name: vector_pingpong_store

Overview:
- Double-banked chunk memory that holds one CG vector (r, p or x). It sits directly upstream of the CG Alu.
- It absorbs the Alu's write-back stream (memoryR_input with result_mem_we_5, and the equivalents for P and X) into the "next" bank.
- It feeds the current iteration's vector to the Alu from the "current" bank through two read ports:
  - a sequential stream, like rKold / pKold_v2, strobed by outsider_read;
  - an addressed port, like rKold_prev, driven by rkold_read_address.
- Banks swap on the iteration-end pulse (mul_add3_finish).

Parameters:
- element_width, 32, bits per element.
- no_of_units, 8, elements per chunk (one memory word).
- memory_height, 1000, chunk depth of each bank.
- address_width, $clog2(memory_height)+1, internal pointer width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- total  in  32  vector length in elements; chunks = total/no_of_units (integer divide); sampled every cycle.
- wr_en  in  1  write strobe into the next bank.
- wr_data  in  element_width*no_of_units  chunk to write.
- seq_rd  in  1  sequential read strobe on the current bank.
- rnd_rd  in  1  addressed read strobe on the current bank.
- rnd_addr  in  32  chunk address for rnd_rd.
- swap  in  1  iteration-end pulse; exchanges the banks.
- seq_data  out  element_width*no_of_units  sequential read data.
- seq_valid  out  1  seq_data valid pulse.
- seq_last  out  1  asserted with the valid of chunk chunks-1.
- rnd_data  out  element_width*no_of_units  addressed read data.
- rnd_valid  out  1  rnd_data valid pulse.
- wr_count  out  32  chunks written into the next bank since the last swap.
- wr_full  out  1  level; wr_count == chunks.
- bank_sel  out  1  current-bank index.
- err  out  3  sticky {swap_incomplete, rnd_oob, wr_overflow}.

Behaviour:
- Reset (reset==0, asynchronous):
  - all outputs 0; bank_sel=0; internal seq_ptr=0, wr_ptr=0.
  - RAM contents are not cleared.
  - Reset mid-stream abandons any in-flight read: the valid is not asserted after release.
- Banks: bank[bank_sel] is current (read only); bank[~bank_sel] is next (write only). Reads and writes never address the same bank, so no bypass logic exists.
- Write path:
  - On wr_en with wr_ptr<chunks: write wr_data to next[wr_ptr], then wr_ptr++ and wr_count++.
  - On wr_en with wr_ptr>=chunks: write dropped; err[0] set.
  - wr_full is combinational from wr_count and chunks.
- Sequential read:
  - On seq_rd, register seq_data=current[seq_ptr] and assert seq_valid the next cycle (1-cycle latency, single-cycle pulse).
  - seq_last is asserted with the same valid when seq_ptr was chunks-1.
  - seq_ptr wraps to 0 after chunks-1.
  - Back-to-back strobes give back-to-back valids.
- Addressed read:
  - On rnd_rd, return current[rnd_addr] with 1-cycle latency and a rnd_valid pulse.
  - If rnd_addr>=chunks: rnd_data=0, rnd_valid still pulses, err[1] set.
- Swap:
  - On swap: bank_sel toggles; wr_ptr, wr_count and seq_ptr become 0.
  - If wr_count!=chunks at swap, err[2] set; the swap still happens.
- Simultaneous events in the swap cycle:
  - A write in the same cycle lands in the pre-swap next bank and counts toward the err[2] check.
  - seq_rd / rnd_rd in the same cycle read the pre-swap current bank. The data returns next cycle; seq_ptr is still forced to 0.
- seq_rd and rnd_rd in the same cycle are independent; both valids may pulse together.
- chunks==0 (total<no_of_units):
  - writes all overflow (err[0]);
  - seq reads return current[0] with seq_last=1;
  - rnd reads are out-of-bounds.
- err bits clear only on reset.
- Initial vector load: write all chunks into the next bank, then pulse swap once.
- Widths: pointers are address_width bits; total is compared after zero-extension.

Test Plan:
- Load and read back: total=32 (chunks=4); write chunks D0..D3 with wr_en held for 4 cycles, then swap; seq_rd for 4 cycles -> seq_data D0..D3 one cycle after each strobe; seq_last only with D3; bank_sel=1; err=0.
- Wrap and overflow: continue seq_rd for a 5th cycle -> returns D0. Write a 5th chunk before swap -> wr_count stays 4, wr_full=1, err[0]=1.
- Ping-pong: after the first swap, write E0..E3 while streaming D0..D3 in the same cycles -> stream unaffected. Swap -> stream yields E0..E3, bank_sel=0.
- Addressed read: rnd_addr=2 -> rnd_data=current chunk 2 after 1 cycle. rnd_addr=7 -> rnd_data=0, rnd_valid=1, err[1]=1.
- Swap collisions: swap asserted together with wr_en (3rd chunk, wr_count was 2) and seq_rd -> read data from the old bank; err[2]=1 (3!=4); seq_ptr restarts at 0.
- Async reset mid-stream: drop reset during a seq_rd cycle -> outputs 0 immediately with no valid on release. Subsequent seq_rd -> returns bank 0, chunk 0, whose contents are retained.
